lnrv_idu_ibuf: RTL
==================

// Module: lnrv_idu_ibuf
// PURPOSE
//  Parametrised instruction buffer between the IFU and IDU decode. It queues fetched
//  {ir, pc, misalgn, buserr} entries and adds optional empty-bypass and a fault fence.
//  It also implements the pipeline halt/flush handshake on behalf of the decode stage.
//  Upstream fetch bursts are decoupled from downstream decode stalls.
// PARAMETERS
//  DEPTH   4   entries; power of two, >=2
//  IR_W    32  instruction width
//  PC_W    32  pc width
//  BYPASS  1   1: an empty buffer forwards IFU input combinationally; 0: always >=1 cycle
// PORTS
//  clk             in   1              clock
//  reset           in   1              synchronous, active-high reset
//  ifu_ir_vld      in   1              upstream entry valid
//  ifu_ir_rdy      out  1              upstream accept
//  ifu_ir          in   IR_W           instruction
//  ifu_pc          in   PC_W           pc of instruction
//  ifu_misalgn     in   1              fetch misaligned fault
//  ifu_buserr      in   1              fetch bus error
//  pipe_halt_req   in   1              level; stop fetch intake, drain
//  pipe_halt_ack   out  1              level; halted and empty
//  pipe_flush_req  in   1              discard all buffered entries
//  pipe_flush_ack  out  1              1-cycle pulse, flush done
//  ibuf_ir_vld     out  1              downstream entry valid
//  ibuf_ir_rdy     in   1              decode accept
//  ibuf_ir/pc      out  IR_W/PC_W      head entry
//  ibuf_misalgn    out  1              head entry fault flag
//  ibuf_buserr     out  1              head entry fault flag
//  ibuf_cnt        out  $clog2(DEPTH+1) occupancy
// BEHAVIOUR
//  - Reset: rd/wr ptrs=0, cnt=0, fence=0, halt_ack=0, flush_ack=0; ibuf_ir_vld=0. Data regs not reset.
//  - Push when ifu_ir_vld&ifu_ir_rdy; pop when ibuf_ir_vld&ibuf_ir_rdy. Simultaneous push+pop keeps cnt.
//  - ifu_ir_rdy = !full_after_pop & !pipe_halt_req & !fence & !pipe_flush_req. Full with same-cycle pop
//    accepts a push (rdy depends on ibuf_ir_rdy).
//  - ibuf_ir_vld = (cnt!=0) | (BYPASS & cnt==0 & ifu_ir_vld & ifu_ir_rdy).
//    A bypass entry consumed in the same cycle is not written. Otherwise latency is 1 cycle, ptrs wrap mod DEPTH.
//  - Fault fence: accepting an entry with misalgn|buserr sets fence. fence holds ifu_ir_rdy=0 until a flush.
//    Buffered entries still drain.
//  - Flush: pipe_flush_req has priority over push/pop in its cycle. No pop is reported (ibuf_ir_vld=0 that cycle).
//    Next edge: cnt=0, ptrs=0, fence=0. pipe_flush_ack=1 for exactly that following cycle.
//    A held req re-flushes each cycle and re-pulses ack.
//  - Halt: while pipe_halt_req=1, no pushes and pops continue.
//    pipe_halt_ack registered = pipe_halt_req & cnt==0; it rises 1 cycle after empty and drops 1 cycle after req drops.
//  - Flush during halt: buffer empties, ack follows the next cycle.
//  - Reset mid-operation discards all entries and pending acks.
//  - cnt never exceeds DEPTH and never underflows. Pop on empty is impossible because vld=0.
// STRUCTURE
//  - lnrv_def.v: IBUF entry field offsets / packed entry width macro (IR_W+PC_W+2) for reuse by IDU.
//  - One sub-module: lnrv_ibuf_fifo (generic sync FIFO: ptrs, cnt, full/empty, flush).
//  - Top adds the bypass mux, fence flop and halt/flush ack logic.
// TESTING
//  1 Reset, then ifu pushes ir=0x10500073 pc=0x80 with ibuf_ir_rdy=1, BYPASS=1 -> same-cycle ibuf_ir_vld, cnt stays 0
//  2 ibuf_ir_rdy=0, push 5 entries pc=0x0,4,8,C,10 (DEPTH=4) -> cnt=4, ifu_ir_rdy=0 on the 5th
//    Then release -> pops in order 0x0..0xC, wrap correct
//  3 Full plus simultaneous pop and push -> accepted, cnt stays 4, order preserved
//  4 Push pc=0x20 buserr=1 then pc=0x24 -> 0x24 blocked (ifu_ir_rdy=0)
//    0x20 drains with ibuf_buserr=1; flush reopens intake
//  5 Halt with cnt=3, ibuf_ir_rdy=1 -> no pushes, halt_ack=1 one cycle after cnt=0, drops 1 cycle after req low
//  6 Flush with cnt=2 plus concurrent push -> push dropped, next cycle cnt=0, flush_ack pulse 1 cycle
//    Reset pulse mid-burst -> cnt=0, vld=0

Source files
------------

// File: rtl/lnrv_idu_ibuf_pkg.sv
// Shared definitions for the IDU instruction buffer: packed entry layout and sizing helpers.
// Entry layout (LSB first): buserr, misalgn, pc[PC_W], ir[IR_W].
package lnrv_idu_ibuf_pkg;

  localparam int IBUF_BUSERR_BIT  = 0;
  localparam int IBUF_MISALGN_BIT = 1;
  localparam int IBUF_PC_LSB      = 2;

  function automatic int ibuf_ir_lsb(input int pc_w);
    return pc_w + IBUF_PC_LSB;
  endfunction

  function automatic int ibuf_entry_w(input int ir_w, input int pc_w);
    return ir_w + pc_w + 2;
  endfunction

endpackage

// File: rtl/lnrv_ibuf_fifo.sv
// Generic synchronous FIFO with occupancy count and a flush that empties it in one edge.
// Flush wins over push/pop in the same cycle; storage is not reset.
module lnrv_ibuf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/lnrv_idu_ibuf.sv
// Instruction buffer between IFU and decode: FIFO plus empty-bypass, fault fence and
// halt/flush acknowledge. Handshake: a transfer happens on a cycle where vld & rdy are both 1.
module lnrv_idu_ibuf
  import lnrv_idu_ibuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IR_W   = 32,
  parameter int PC_W   = 32,
  parameter int BYPASS = 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_ir_vld,
  output logic            ifu_ir_rdy,
  input  logic [IR_W-1:0] ifu_ir,
  input  logic [PC_W-1:0] ifu_pc,
  input  logic            ifu_misalgn,
  input  logic            ifu_buserr,
  input  logic            pipe_halt_req,
  output logic            pipe_halt_ack,
  input  logic            pipe_flush_req,
  output logic            pipe_flush_ack,
  output logic            ibuf_ir_vld,
  input  logic            ibuf_ir_rdy,
  output logic [IR_W-1:0] ibuf_ir,
  output logic [PC_W-1:0] ibuf_pc,
  output logic            ibuf_misalgn,
  output logic            ibuf_buserr,
  output logic [CW-1:0]   ibuf_cnt
);

  localparam int EW     = ibuf_entry_w(IR_W, PC_W);
  localparam int IR_LSB = ibuf_ir_lsb(PC_W);

  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass_vld;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fence_q;
  logic          halt_ack_q;
  logic          flush_ack_q;

  assign wr_entry = {ifu_ir, ifu_pc, ifu_misalgn, ifu_buserr};

  // When full, ibuf_ir_vld is known to be 1, so a decode accept frees a slot this cycle.
  assign ifu_ir_rdy = !(full && !ibuf_ir_rdy) && !pipe_halt_req && !fence_q && !pipe_flush_req;
  assign push       = ifu_ir_vld && ifu_ir_rdy;
  assign bypass_vld = (BYPASS != 0) && empty && push;
  assign ibuf_ir_vld = !pipe_flush_req && (!empty || bypass_vld);
  assign pop        = ibuf_ir_vld && ibuf_ir_rdy;

  // A bypassed entry taken by decode in the same cycle never enters storage.
  assign fifo_push = push && !(bypass_vld && ibuf_ir_rdy);
  assign fifo_pop  = pop && !empty;

  lnrv_ibuf_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (pipe_flush_req),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (rd_entry),
    .cnt   (ibuf_cnt),
    .full  (full),
    .empty (empty)
  );

  assign head         = empty ? wr_entry : rd_entry;
  assign ibuf_ir      = head[IR_LSB +: IR_W];
  assign ibuf_pc      = head[IBUF_PC_LSB +: PC_W];
  assign ibuf_misalgn = head[IBUF_MISALGN_BIT];
  assign ibuf_buserr  = head[IBUF_BUSERR_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      fence_q     <= 1'b0;
      halt_ack_q  <= 1'b0;
      flush_ack_q <= 1'b0;
    end else begin
      flush_ack_q <= pipe_flush_req;
      halt_ack_q  <= pipe_halt_req && empty;
      if (pipe_flush_req)
        fence_q <= 1'b0;
      else if (push && (ifu_misalgn || ifu_buserr))
        fence_q <= 1'b1;
    end
  end

  assign pipe_halt_ack  = halt_ack_q;
  assign pipe_flush_ack = flush_ack_q;

endmodule
